xbus_init16: RTL
================

XBUS_INIT16 -- requirements
Module: xbus_init16

Interface
REQ-001 Parameter WAITS, default 0: fixed wait cycles inserted between address phase and transfer phase (0..7).
REQ-002 Parameter TIMEOUT, default 15: max XFER cycles with rdy=0 before abort (1..255; used only with XBUS_TIMEOUT_EN).
REQ-003 One clock, clk; reset rst is asynchronous, active-high.
REQ-004 clk  in  1  global clock.
REQ-005 rst  in  1  global async reset, active-high.
REQ-006 req  in  1  client transaction request, sampled in IDLE only.
REQ-007 we  in  1  1=write, 0=read.
REQ-008 be  in  2  byte enables; be[1]=d[15:8], be[0]=d[7:0].
REQ-009 addr  in  7  addr[6:5] peripheral index, addr[4:0] peripheral-local address.
REQ-010 wdata  in  16  write data.
REQ-011 rdata  out  16  read data, valid with ack on reads.
REQ-012 ack  out  1  one-cycle completion pulse.
REQ-013 err  out  1  one-cycle abort flag, coincident with ack.
REQ-014 ctrl  out  16  abstract control bus to all peripherals.
REQ-015 sel  out  4  one-hot peripheral selects.
REQ-016 rdy  in  1  peripheral ready, 1 = transfer may complete.
REQ-017 d  inout  16  shared tristate on-chip data bus.

Function
REQ-018 ctrl encoding: [4:0] address, [5] RD, [6] WRU, [7] WRL, [15:8] always 0.
REQ-019 FSM states IDLE, ADDR, WAIT, XFER, DONE; IDLE with req=1 latches we/be/addr/wdata, goes to ADDR; req ignored in all other states.
REQ-020 be=00 request: IDLE -> DONE directly, no sel, no strobes, ack=1, err=0, rdata unchanged.
REQ-021 ADDR: one cycle; ctrl[4:0]=latched addr, sel bit addr[6:5] high, strobes 0; -> WAIT if WAITS>0 else XFER.
REQ-022 WAIT: exactly WAITS cycles, address/sel held, strobes 0; -> XFER.
REQ-023 XFER: address/sel held; read asserts RD; write asserts WRU=be[1], WRL=be[0]; stays while rdy=0.
REQ-024 d driven only in XFER on writes, and only halves with be set; otherwise both halves high-Z.
REQ-025 Read: rdata loads d on the XFER cycle where rdy=1, disabled halves (be=0) load 0.
REQ-026 XFER with rdy=1 -> DONE; DONE: ack=1, sel=0, ctrl=0, d released; -> IDLE.
REQ-027 Latency, WAITS=0, rdy=1: req sampled edge N, ack high in cycle N+3; each wait/stall cycle adds 1.
REQ-028 Back-to-back: req held high issues a new transaction on the IDLE cycle following DONE (min 4-cycle period).
REQ-029 Outside ADDR/WAIT/XFER, sel=0 and ctrl=0.

Reset
REQ-030 rst asserted in any state: immediately IDLE, ack=0, err=0, sel=0, ctrl=0, rdata=0, d high-Z, wait/timeout counters 0.
REQ-031 Aborted transaction by reset produces no ack; first request after rst deassertion starts normally.

Configuration
REQ-032 Macro XBUS_TIMEOUT_EN defined: XFER counts consecutive rdy=0 cycles; on reaching TIMEOUT -> DONE with ack=1, err=1, rdata unchanged, strobes dropped.
REQ-033 Macro XBUS_TIMEOUT_EN undefined: XFER waits indefinitely for rdy; err tied 0; no timeout counter logic.

Structure
REQ-034 Package xbus_pkg holds ctrl bit positions, ctrl width, peripheral count (4), FSM state encoding.
REQ-035 Sub-module xbus_tmo (saturating stall counter with clear/expire) instantiated only under XBUS_TIMEOUT_EN.

Verification
REQ-036 Write addr=7'h25, be=11, wdata=16'hA55A, WAITS=0, rdy=1 -> sel=4'b0010, ctrl=16'h00C5 during XFER, d=A55A in XFER only, ack at N+3.
REQ-037 Read addr=7'h03, be=01, peripheral drives d=16'h1234 -> RD set, d undriven by block, rdata=16'h0034, ack at N+3.
REQ-038 WAITS=2, rdy low 3 XFER cycles -> ack at N+8, strobes held throughout, no err.
REQ-039 With XBUS_TIMEOUT_EN, TIMEOUT=4, rdy stuck 0 -> ack+err after 4 XFER cycles, rdata unchanged, sel/ctrl 0 next cycle.
REQ-040 rst pulsed mid-XFER of a write -> d high-Z and sel=0 same cycle, no ack; be=00 request afterwards -> ack at N+1, no sel.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared definitions for the xbus_init16 on-chip bus initiator: ctrl bit map,
// widths, peripheral count and FSM state encoding.
package xbus_pkg;

  localparam int DATA_W      = 16;
  localparam int CTRL_W      = 16;
  localparam int CTRL_ADDR_W = 5;
  localparam int CTRL_RD     = 5;
  localparam int CTRL_WRU    = 6;
  localparam int CTRL_WRL    = 7;
  localparam int NUM_PERIPH  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_XFER = 3'd3,
    ST_DONE = 3'd4
  } xbus_state_e;

  function automatic logic [NUM_PERIPH-1:0] periph_sel(input logic [1:0] idx);
    logic [NUM_PERIPH-1:0] s;
    s      = '0;
    s[idx] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/xbus_tmo.sv
// Saturating count of consecutive stalled transfer cycles; expire flags the
// stall cycle that reaches TIMEOUT.
module xbus_tmo #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic stall,
  output logic expire
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != TMO_MAX)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = stall && (cnt_q >= TMO_LAST);

endmodule

// File: rtl/xbus_init16.sv
// Single-initiator 16-bit tristate bus master: address, optional wait, transfer.
// Optional XFER stall timeout is built only when XBUS_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for req; latches the request
// ADDR  | one address cycle, sel/address out, no strobes
// WAIT  | WAITS fixed cycles, address held
// XFER  | strobes active, waits for rdy (or timeout)
// DONE  | ack (and err on timeout), bus released
module xbus_init16
  import xbus_pkg::*;
#(
  parameter int WAITS   = 0,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [6:0]            addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ack,
  output logic                  err,
  output logic [CTRL_W-1:0]     ctrl,
  output logic [NUM_PERIPH-1:0] sel,
  input  logic                  rdy,
  inout  wire  [DATA_W-1:0]     d
);

  if ((WAITS < 0) || (WAITS > 7) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_param
    $error("xbus_init16: WAITS must be 0..7 and TIMEOUT 1..255");
  end

  localparam logic [2:0] WAIT_LOAD = (WAITS > 0) ? 3'(WAITS - 1) : 3'd0;

  xbus_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [6:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              drv_hi, drv_lo;
  logic              tmo_expire;

`ifdef XBUS_TIMEOUT_EN
  logic err_q, err_d;

  xbus_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q != ST_XFER) || rdy),
    .stall  ((state_q == ST_XFER) && !rdy),
    .expire (tmo_expire)
  );

  always_comb err_d = (state_q == ST_XFER) && !rdy && tmo_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          addr_d  = addr;
          wdata_d = wdata;
          // an empty byte mask completes without touching the bus
          state_d = (be == 2'b00) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (WAITS > 0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = ST_XFER;
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      ST_XFER: begin
        if (rdy) begin
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = {be_q[1] ? d[15:8] : 8'h00, be_q[0] ? d[7:0] : 8'h00};
          end
        end else if (tmo_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel    = '0;
    ctrl   = '0;
    ack    = 1'b0;
    drv_hi = 1'b0;
    drv_lo = 1'b0;
    case (state_q)
      ST_ADDR, ST_WAIT: begin
        sel                    = periph_sel(addr_q[6:5]);
        ctrl[CTRL_ADDR_W-1:0]  = addr_q[4:0];
      end
      ST_XFER: begin
        sel                    = periph_sel(addr_q[6:5]);
        ctrl[CTRL_ADDR_W-1:0]  = addr_q[4:0];
        if (we_q) begin
          ctrl[CTRL_WRU] = be_q[1];
          ctrl[CTRL_WRL] = be_q[0];
          drv_hi         = be_q[1];
          drv_lo         = be_q[0];
        end else begin
          ctrl[CTRL_RD] = 1'b1;
        end
      end
      ST_DONE: ack = 1'b1;
      default: ;
    endcase
  end

  assign d[15:8] = drv_hi ? wdata_q[15:8] : 8'hzz;
  assign d[7:0]  = drv_lo ? wdata_q[7:0]  : 8'hzz;
  assign rdata   = rdata_q;

endmodule
